// File: rtl/sumrest_seq_ctrl_if.sv
// Bundle of operand/result handshake and external 4-bit slice signals for sumrest_seq_ctrl.
// slave = controller view, master = environment (operand source + slice) view.
interface sumrest_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         resta;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_s;
  logic         slice_cout;
  logic         slice_c3;

  modport slave (
    input  start, resta, op_a, op_b, slice_s, slice_cout, slice_c3,
    output busy, done, result, carry, overflow, zero, slice_a, slice_b, slice_cin
  );

  modport master (
    output start, resta, op_a, op_b, slice_s, slice_cout, slice_c3,
    input  busy, done, result, carry, overflow, zero, slice_a, slice_b, slice_cin
  );
endinterface

// File: rtl/sumrest_seq_ctrl.sv
// Nibble-serial W-bit add/subtract controller time-sharing one external 4-bit adder slice.
// LSB nibble first; carry chained through r_carry; B inverted and cin=1 for subtraction.
module sumrest_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            reset,
  sumrest_seq_ctrl_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_resta;
  logic [W-1:0]      r_acc;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [W-1:0]      r_result;
  logic              r_carry_out;
  logic              r_overflow;
  logic              r_zero;

  logic [W-1:0]      w_merged;
  logic              w_last;

  assign w_last = (r_idx == IDXW'(NIBBLES - 1));

  // Accumulator with the current slice sum dropped into the active nibble slot.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_merge
    assign w_merged[4*gi +: 4] = (r_idx == IDXW'(gi)) ? bus.slice_s : r_acc[4*gi +: 4];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.slice_a   = 4'h0;
    bus.slice_b   = 4'h0;
    bus.slice_cin = 1'b0;
    case (r_state)
      RUN: begin
        bus.busy      = 1'b1;
        bus.slice_a   = r_a[{r_idx, 2'b00} +: 4];
        bus.slice_b   = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_resta}};
        bus.slice_cin = r_carry;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, nibble accumulation, flag update on the last RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_resta     <= 1'b0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_resta <= bus.resta;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= bus.resta;
          end
        end
        RUN: begin
          r_acc   <= w_merged;
          r_carry <= bus.slice_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_result    <= w_merged;
            r_carry_out <= bus.slice_cout;
            r_overflow  <= bus.slice_cout ^ bus.slice_c3;
            r_zero      <= (w_merged == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.carry    = r_carry_out;
  assign bus.overflow = r_overflow;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_sumrest_seq_ctrl.sv
// Directed bench for sumrest_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder slice.
module tb_sumrest_seq_ctrl;
  localparam int NIB = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [3:0] cin_seq;
  logic [3:0] first_b;

  sumrest_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

  sumrest_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit ripple slice: sum, carry-out and carry into bit 3
  logic [4:0] sum5;
  logic [3:0] low4;
  always_comb begin
    sum5 = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + 5'(bus.slice_cin);
    low4 = {1'b0, bus.slice_a[2:0]} + {1'b0, bus.slice_b[2:0]} + 4'(bus.slice_cin);
  end
  assign bus.slice_s    = sum5[3:0];
  assign bus.slice_cout = sum5[4];
  assign bus.slice_c3   = low4[3];

  // Issues one operation; lat = edges from start edge to done (-1 on timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic rs,
                       input logic scramble, output int lat);
    lat = -1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.resta = rs;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    cin_seq[0] = bus.slice_cin;
    first_b    = bus.slice_b;
    if (scramble) begin
      bus.op_a  = 16'hFFFF;
      bus.op_b  = 16'hA5A5;
      bus.resta = ~rs;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (n < NIB) cin_seq[n] = bus.slice_cin;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_res(input string name, input int lat, input logic [15:0] r,
                           input logic c, input logic v, input logic z);
    n_cmp++;
    if (lat !== NIB) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, NIB);
    end
    n_cmp++;
    if ({bus.result, bus.carry, bus.overflow, bus.zero} !== {r, c, v, z}) begin
      n_err++;
      $display("FAIL %s result/c/v/z: got %h/%b/%b/%b expected %h/%b/%b/%b",
               name, bus.result, bus.carry, bus.overflow, bus.zero, r, c, v, z);
    end
    $display("op %s: result=%h c=%b v=%b z=%b lat=%0d", name, bus.result, bus.carry,
             bus.overflow, bus.zero, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.result, bus.carry, bus.overflow, bus.zero} !== 20'h0) begin
      n_err++;
      $display("FAIL reset outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b expected all 0",
               bus.busy, bus.done, bus.result, bus.carry, bus.overflow, bus.zero);
    end
    n_cmp++;
    if ({bus.slice_a, bus.slice_b, bus.slice_cin} !== 9'h0) begin
      n_err++;
      $display("FAIL reset slice drive: got %h %h %b expected 0 0 0",
               bus.slice_a, bus.slice_b, bus.slice_cin);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%b result=%h", bus.busy, bus.result);
  endtask

  task automatic test_add();
    int lat;
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat);
    check_res("add", lat, 16'h2201, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (cin_seq !== 4'b1110) begin
      n_err++;
      $display("FAIL add cin_seq (idx3..0): got %b expected 1110", cin_seq);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
    check_res("sub", lat, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({first_b, cin_seq[0]} !== {4'h8, 1'b1}) begin
      n_err++;
      $display("FAIL sub first slice_b/cin: got %h/%b expected 8/1", first_b, cin_seq[0]);
    end
  endtask

  task automatic test_overflow_wrap();
    int lat;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check_res("ovf", lat, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check_res("wrap", lat, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_equal_and_latch();
    int lat;
    do_op(16'h1234, 16'h1234, 1'b1, 1'b0, lat);
    check_res("eqsub", lat, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(16'h0100, 16'h0001, 1'b0, 1'b1, lat);
    check_res("latch", lat, 16'h0101, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int dcount;
    dcount = 0;
    bus.op_a  = 16'h0003;
    bus.op_b  = 16'h0004;
    bus.resta = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dcount++;
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h2222;
        bus.start = 1'b1;
      end else if (n == 1) begin
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h2222;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_cmp++;
    if (dcount !== 1) begin
      n_err++;
      $display("FAIL busy_start done pulses: got %0d expected 1", dcount);
    end
    n_cmp++;
    if ({bus.result, bus.busy} !== {16'h0007, 1'b0}) begin
      n_err++;
      $display("FAIL busy_start result/busy: got %h/%b expected 0007/0", bus.result, bus.busy);
    end
    $display("busy_start: done_pulses=%0d result=%h", dcount, bus.result);
  endtask

  task automatic test_reset_mid();
    int dcount;
    int lat;
    dcount = 0;
    bus.op_a  = 16'h4444;
    bus.op_b  = 16'h1111;
    bus.resta = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.result} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_mid busy/done/result: got %b/%b/%h expected 0/0/0000",
               bus.busy, bus.done, bus.result);
    end
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    n_cmp++;
    if (dcount !== 0) begin
      n_err++;
      $display("FAIL reset_mid spurious done: got %0d expected 0", dcount);
    end
    $display("reset_mid: result=%h spurious_done=%0d", bus.result, dcount);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    check_res("after_reset", lat, 16'h0100, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cin_seq   = '0;
    first_b   = '0;
    bus.start = 1'b0;
    bus.resta = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    test_reset();
    test_add();
    test_sub();
    test_overflow_wrap();
    test_equal_and_latch();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
